// File: rtl/vx_raster_slice_sched_if.sv
// Signal bundle between the raster slice scheduler, the frame start logic,
// the raster memory units and the downstream rasterizer.
interface vx_raster_slice_sched_if #(
  parameter int NUM_SLICES = 4,
  parameter int DATAW      = 64,
  parameter int CNT_BITS   = 32,
  parameter int SRCW       = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
);
  logic                        start_req;
  logic [NUM_SLICES-1:0]       mem_start;
  logic [NUM_SLICES-1:0]       mem_busy;
  logic [NUM_SLICES-1:0]       in_valid;
  logic [NUM_SLICES*DATAW-1:0] in_data;
  logic [NUM_SLICES-1:0]       in_ready;
  logic                        out_valid;
  logic [DATAW-1:0]            out_data;
  logic [SRCW-1:0]             out_src;
  logic                        out_ready;
  logic                        busy;
  logic                        done;
  logic [CNT_BITS-1:0]         prim_count;

  modport master (
    input  start_req, mem_busy, in_valid, in_data, out_ready,
    output mem_start, in_ready, out_valid, out_data, out_src, busy, done, prim_count
  );

  modport slave (
    output start_req, mem_busy, in_valid, in_data, out_ready,
    input  mem_start, in_ready, out_valid, out_data, out_src, busy, done, prim_count
  );
endinterface

// File: rtl/vx_raster_slice_sched.sv
// Launches the raster memory units for a frame, round-robin merges their outputs
// into one registered stream and signals frame completion.
module vx_raster_slice_sched #(
  parameter int NUM_SLICES  = 4,
  parameter int DATAW       = 64,
  parameter int START_DELAY = 2,
  parameter int CNT_BITS    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_raster_slice_sched_if.master bus
);
  localparam int SRCW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int DLYW = $clog2(START_DELAY + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [DLYW-1:0]       cnt_reg, cnt_next;
  logic [SRCW-1:0]       ptr_reg, ptr_next;
  logic [NUM_SLICES-1:0] mem_start_reg;
  logic                  out_valid_reg;
  logic [DATAW-1:0]      out_data_reg;
  logic [SRCW-1:0]       out_src_reg;
  logic [CNT_BITS-1:0]   prim_count_reg;

  logic                  launch;
  logic                  active;
  logic                  can_load;
  logic                  accept;
  logic                  fire;
  logic                  grant_found;
  logic [SRCW-1:0]       grant_idx;
  logic [NUM_SLICES-1:0] grant_oh;
  logic [DATAW-1:0]      grant_data;
  logic [DATAW-1:0]      slice_data [NUM_SLICES];
  int                    cand;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Unit busy flags are not trusted during LAUNCH: units need time to raise them.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    launch     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start_req) begin
          launch     = 1'b1;
          state_next = LAUNCH;
          cnt_next   = DLYW'(START_DELAY);
        end
      end
      LAUNCH: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == DLYW'(1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (~|bus.mem_busy && ~|bus.in_valid && !out_valid_reg) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign active   = (state_reg == LAUNCH) || (state_reg == RUN);
  assign can_load = !out_valid_reg || bus.out_ready;

  // Search order starts at the pointer and wraps; first valid unit wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    cand        = 0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      cand = int'(ptr_reg) + i;
      if (cand >= NUM_SLICES) begin
        cand = cand - NUM_SLICES;
      end
      for (int j = 0; j < NUM_SLICES; j++) begin
        if (!grant_found && (cand == j) && bus.in_valid[j]) begin
          grant_found = 1'b1;
          grant_idx   = SRCW'(j);
          grant_oh[j] = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
    assign slice_data[gi] = grant_oh[gi] ? bus.in_data[gi*DATAW +: DATAW] : '0;
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      grant_data = grant_data | slice_data[k];
    end
  end

  assign accept   = active && can_load && grant_found;
  assign fire     = out_valid_reg && bus.out_ready;
  assign ptr_next = (grant_idx == SRCW'(NUM_SLICES - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_reg        <= '0;
      mem_start_reg  <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_src_reg    <= '0;
      prim_count_reg <= '0;
    end else begin
      mem_start_reg <= {NUM_SLICES{launch}};
      // A reload on the same cycle as a fire keeps the stream at full rate.
      if (accept) begin
        ptr_reg       <= ptr_next;
        out_valid_reg <= 1'b1;
        out_data_reg  <= grant_data;
        out_src_reg   <= grant_idx;
      end else if (fire) begin
        out_valid_reg <= 1'b0;
      end
      if (launch) begin
        prim_count_reg <= '0;
      end else if (fire && !(&prim_count_reg)) begin
        prim_count_reg <= prim_count_reg + 1'b1;
      end
    end
  end

  assign bus.mem_start  = mem_start_reg;
  assign bus.in_ready   = (active && can_load) ? grant_oh : '0;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.out_src    = out_src_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE);
  assign bus.prim_count = prim_count_reg;
endmodule

// File: tb/tb_vx_raster_slice_sched.sv
// Bench for vx_raster_slice_sched: unit queues feed the DUT, a round-robin
// reference over those queues predicts the merged stream.
module tb_vx_raster_slice_sched;
  localparam int NS   = 4;
  localparam int DW   = 64;
  localparam int SD   = 2;
  localparam int CB   = 32;
  localparam int SRCW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_raster_slice_sched_if #(.NUM_SLICES(NS), .DATAW(DW), .CNT_BITS(CB)) bus ();

  vx_raster_slice_sched #(
    .NUM_SLICES(NS), .DATAW(DW), .START_DELAY(SD), .CNT_BITS(CB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] uq [NS][$];
  int            busy_extra [NS];
  logic [DW-1:0] exp_data_q [$];
  int            exp_src_q [$];
  int            model_ptr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: every nonempty unit presents its head continuously, so the merged
  // order is a plain round-robin walk over the queues from the current pointer.
  task automatic build_expected();
    int rem_idx [NS];
    int left;
    left = 0;
    for (int u = 0; u < NS; u++) begin
      rem_idx[u] = 0;
      left += uq[u].size();
    end
    while (left > 0) begin
      for (int k = 0; k < NS; k++) begin
        int u;
        u = (model_ptr + k) % NS;
        if (rem_idx[u] < uq[u].size()) begin
          exp_data_q.push_back(uq[u][rem_idx[u]]);
          exp_src_q.push_back(u);
          rem_idx[u]++;
          left--;
          model_ptr = (u + 1) % NS;
          break;
        end
      end
    end
  endtask

  task automatic fill(input int n_lo, input int n_hi, input int extra_hi);
    for (int u = 0; u < NS; u++) begin
      int n;
      uq[u].delete();
      n = $urandom_range(n_hi, n_lo);
      for (int k = 0; k < n; k++) uq[u].push_back({$urandom, $urandom});
      busy_extra[u] = $urandom_range(extra_hi, 0);
    end
  endtask

  task automatic drive_units();
    for (int u = 0; u < NS; u++) begin
      bus.in_valid[u] = (uq[u].size() > 0);
      bus.in_data[u*DW +: DW] = (uq[u].size() > 0) ? uq[u][0] : {$urandom, $urandom};
      bus.mem_busy[u] = (uq[u].size() > 0) || (busy_extra[u] > 0);
    end
  endtask

  task automatic run_frame(input int stall_lo, input int stall_hi, input bit rand_ready,
                           input int poke_cyc, input int exp_done, input bit check_lat);
    int            total;
    int            fire_idx;
    int            prim_now;
    int            cyc;
    bit            seen_done;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [SRCW-1:0] prev_src;
    exp_data_q.delete();
    exp_src_q.delete();
    build_expected();
    total = exp_data_q.size();
    fire_idx = 0; prim_now = 0; seen_done = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_src = '0;
    drive_units();
    bus.start_req = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start_req = 1'b0;
    for (cyc = 1; cyc <= 150 && !seen_done; cyc++) begin
      for (int u = 0; u < NS; u++)
        if (uq[u].size() == 0 && busy_extra[u] > 0) busy_extra[u]--;
      drive_units();
      bus.start_req = (cyc == poke_cyc) || (cyc == poke_cyc + 1);
      if (cyc >= stall_lo && cyc <= stall_hi) bus.out_ready = 1'b0;
      else bus.out_ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
      @(negedge clk);
      check("mem_start", 64'(bus.mem_start), (cyc == 1) ? 64'hF : 64'h0);
      check("busy", 64'(bus.busy), 64'd1);
      check("prim_count", 64'(bus.prim_count), 64'(prim_now));
      check("in_ready_onehot0", 64'($onehot0(bus.in_ready)), 64'd1);
      if (bus.out_valid && !bus.out_ready) check("in_ready_blocked", 64'(bus.in_ready), 64'd0);
      if (prev_stall) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", bus.out_data, prev_data);
        check("hold_src", 64'(bus.out_src), 64'(prev_src));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_data_q.size() == 0) begin
          check("output_count", 64'(fire_idx + 1), 64'(total));
        end else begin
          check("out_src", 64'(bus.out_src), 64'(exp_src_q.pop_front()));
          check("out_data", bus.out_data, exp_data_q.pop_front());
          if (check_lat) check("fire_cycle", 64'(cyc), 64'(fire_idx + 2));
        end
        fire_idx++;
        prim_now++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_src   = bus.out_src;
      for (int u = 0; u < NS; u++)
        if (bus.in_valid[u] && bus.in_ready[u]) void'(uq[u].pop_front());
      if (bus.done) begin
        seen_done = 1'b1;
        check("done_drained", 64'(exp_data_q.size()), 64'd0);
        check("done_count", 64'(bus.prim_count), 64'(total));
        check("done_units_idle", 64'(bus.mem_busy), 64'd0);
        if (exp_done >= 0) check("done_cycle", 64'(cyc), 64'(exp_done));
      end
      @(posedge clk); #1;
    end
    check("frame_done_seen", 64'(seen_done), 64'd1);
    drive_units();
    @(negedge clk);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);
    $display("[TB] frame: %0d items, %0d delivered, done=%0b", total, fire_idx, seen_done);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.start_req = 1'b0; bus.out_ready = 1'b0;
    bus.in_valid = '0; bus.mem_busy = '0; bus.in_data = '0;
    for (int u = 0; u < NS; u++) busy_extra[u] = 0;

    // Reset with random inputs
    for (int c = 0; c < 3; c++) begin
      bus.start_req = 1'($urandom);
      bus.in_valid  = NS'($urandom);
      bus.mem_busy  = NS'($urandom);
      bus.out_ready = 1'($urandom);
      for (int u = 0; u < NS; u++) bus.in_data[u*DW +: DW] = {$urandom, $urandom};
      @(posedge clk); #1;
      check("rst_mem_start", 64'(bus.mem_start), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", bus.out_data, 64'd0);
      check("rst_out_src", 64'(bus.out_src), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_prim_count", 64'(bus.prim_count), 64'd0);
      $display("[TB] reset cycle %0d checked", c);
    end
    reset = 1'b1;
    bus.start_req = 1'b0; bus.in_valid = '0; bus.mem_busy = '0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    // Empty frame: fixed START_DELAY+2 completion
    fill(0, 0, 0);
    run_frame(-1, -1, 1'b0, -10, SD + 2, 1'b0);

    // Two items per unit, full throughput
    fill(2, 2, 0);
    run_frame(-1, -1, 1'b0, -10, 11, 1'b1);

    // Same load with a five-cycle downstream stall
    fill(2, 2, 0);
    run_frame(4, 8, 1'b0, -10, 16, 1'b0);

    // start_req pulsed mid-frame is ignored
    fill(3, 3, 0);
    run_frame(-1, -1, 1'b1, 4, -1, 1'b0);

    // Random loads, busy tails and backpressure
    for (int f = 0; f < 20; f++) begin
      fill(0, 4, 3);
      run_frame(-1, -1, 1'b1, -10, -1, 1'b0);
    end

    // Reset in RUN with a held output
    fill(3, 3, 0);
    drive_units();
    bus.start_req = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      drive_units();
      bus.out_ready = (c <= 3);
      @(negedge clk);
      if (c == 4) begin
        check("pre_abort_valid", 64'(bus.out_valid), 64'd1);
        check("pre_abort_count", 64'(bus.prim_count), 64'd2);
      end
      for (int u = 0; u < NS; u++)
        if (bus.in_valid[u] && bus.in_ready[u]) void'(uq[u].pop_front());
      @(posedge clk); #1;
    end
    reset = 1'b0;
    drive_units();
    @(posedge clk); #1;
    reset = 1'b1;
    drive_units();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_prim_count", 64'(bus.prim_count), 64'd0);
    check("abort_out_data", bus.out_data, 64'd0);
    $display("[TB] abort cycle checked");
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      drive_units();
      bus.out_ready = 1'($urandom);
      @(negedge clk);
      check("abort_no_done", 64'(bus.done), 64'd0);
      check("abort_stays_idle", 64'(bus.busy), 64'd0);
    end
    @(posedge clk); #1;
    model_ptr = 0;
    fill(1, 3, 2);
    run_frame(-1, -1, 1'b1, -10, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
